// File: rtl/jtag_ni_cmd_engine.sv
// JTAG-to-NoC command engine: queues host commands and replays each one as a
// Wishbone register sequence into a selected NI, then polls it for completion.
module jtag_ni_cmd_engine #(
   parameter int          NUM_CH       = 4,
   parameter logic [31:0] NI_BASE_ADDR = 32'h0,
   parameter logic [31:0] NI_STRIDE    = 32'h8,
   parameter int          CMD_DEPTH    = 4,
   parameter int          PCKw         = 9,
   parameter int          PTRw         = 30,
   parameter int          XYw          = 4,
   parameter int          Dw           = 32,
   parameter int          M_Aw         = 32,
   parameter int          TAGw         = 3,
   parameter int          SELw         = 4,
   parameter int          WAIT_CYCLES  = 8,
   parameter int          POLL_LIMIT   = 255,
   localparam int         CHw          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cmd_valid_i,
   output logic            cmd_ready_o,
   input  logic            cmd_op_i,
   input  logic [CHw-1:0]  cmd_ch_i,
   input  logic [PCKw-1:0] cmd_size_i,
   input  logic [PTRw-1:0] cmd_ptr_i,
   input  logic [XYw-1:0]  cmd_x_i,
   input  logic [XYw-1:0]  cmd_y_i,
   output logic [Dw-1:0]   hdr_o,
   output logic [SELw-1:0] m_sel_o,
   output logic [Dw-1:0]   m_dat_o,
   output logic [M_Aw-1:0] m_addr_o,
   output logic [TAGw-1:0] m_tag_o,
   output logic            m_stb_o,
   output logic            m_cyc_o,
   output logic            m_we_o,
   input  logic [Dw-1:0]   m_dat_i,
   input  logic            m_ack_i,
   input  logic            m_err_i,
   input  logic            m_rty_i,
   output logic            busy_o,
   output logic [15:0]     done_cnt_o,
   output logic            err_o,
   output logic [1:0]      err_code_o,
   input  logic            err_clr_i
);
   localparam int Cw   = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
   localparam int HDRw = 16 + 4 * XYw;
   localparam int WCw  = $clog2(WAIT_CYCLES + 1);
   localparam int PCw  = $clog2(POLL_LIMIT + 1);

   typedef struct packed {
      logic            op;
      logic [CHw-1:0]  ch;
      logic [PCKw-1:0] size;
      logic [PTRw-1:0] ptr;
      logic [XYw-1:0]  x;
      logic [XYw-1:0]  y;
   } cmd_t;

   typedef enum logic [5:0] {
      S_IDLE    = 6'b000001,
      S_WR_SIZE = 6'b000010,
      S_WR_PTR  = 6'b000100,
      S_WAIT    = 6'b001000,
      S_POLL    = 6'b010000,
      S_ERR     = 6'b100000
   } state_t;

   state_t          state, state_n;
   cmd_t            fifo_mem [CMD_DEPTH];
   cmd_t            head, wr_entry;
   logic [Cw-1:0]   wr_ptr, rd_ptr;
   logic [Cw:0]     count;
   logic            push, pop, full;
   logic            act_op;
   logic [CHw-1:0]  act_ch;
   logic [PCKw-1:0] act_size;
   logic [PTRw-1:0] act_ptr;
   logic [WCw-1:0]  wait_cnt;
   logic [PCw-1:0]  poll_cnt;
   logic            rty_gap, bus_act, poll_inc, done_inc, pend_set;
   logic [1:0]      pend_val, err_pend;
   logic [M_Aw-1:0] base;
   logic [HDRw-1:0] hdr_full;
   logic            unused_dat;

   always_comb begin
      full        = (count == (Cw+1)'(CMD_DEPTH));
      pop         = (state == S_IDLE) && (count != '0);
      cmd_ready_o = ~full | pop;
      push        = cmd_valid_i & cmd_ready_o;
      head        = fifo_mem[rd_ptr];
      wr_entry    = '{cmd_op_i, cmd_ch_i, cmd_size_i, cmd_ptr_i, cmd_x_i, cmd_y_i};
      hdr_full    = {8'hFF, 8'h00, head.x, head.y, {(2*XYw){1'b0}}};
      busy_o      = (count != '0) || (state != S_IDLE);
      unused_dat  = ^m_dat_i[Dw-1:1];
   end

   // Bus is released for exactly one cycle after a retry, then the same access repeats.
   always_comb begin
      bus_act  = ((state == S_WR_SIZE) || (state == S_WR_PTR) || (state == S_POLL)) && !rty_gap;
      base     = M_Aw'(NI_BASE_ADDR) + M_Aw'(act_ch) * M_Aw'(NI_STRIDE);
      m_cyc_o  = bus_act;
      m_stb_o  = bus_act;
      m_we_o   = bus_act && (state != S_POLL);
      m_sel_o  = '1;
      m_tag_o  = '0;
      m_addr_o = '0;
      m_dat_o  = '0;
      case (state)
         S_WR_SIZE: begin
            m_addr_o = base + M_Aw'(3);
            m_dat_o  = Dw'(act_size) + Dw'(1);
         end
         S_WR_PTR: begin
            m_addr_o = base + (act_op ? M_Aw'(4) : M_Aw'(5));
            m_dat_o  = Dw'({act_ptr, 2'b00});
         end
         S_POLL:  m_addr_o = base;
         default: ;
      endcase
   end

   always_comb begin
      state_n  = state;
      pend_set = 1'b0;
      pend_val = 2'b00;
      poll_inc = 1'b0;
      done_inc = 1'b0;
      case (state)
         S_IDLE:
            if (pop) begin
               if (32'(head.ch) >= 32'(NUM_CH)) begin
                  state_n  = S_ERR;
                  pend_set = 1'b1;
                  pend_val = 2'b11;
               end else begin
                  state_n = S_WR_SIZE;
               end
            end
         S_WR_SIZE, S_WR_PTR, S_POLL:
            if (bus_act) begin
               if (m_err_i) begin
                  state_n  = S_ERR;
                  pend_set = 1'b1;
                  pend_val = 2'b01;
               end else if (m_ack_i) begin
                  if (state == S_WR_SIZE) state_n = S_WR_PTR;
                  else if (state == S_WR_PTR) state_n = S_WAIT;
                  else if (m_dat_i[0]) begin
                     if (32'(poll_cnt) + 32'd1 >= 32'(POLL_LIMIT)) begin
                        state_n  = S_ERR;
                        pend_set = 1'b1;
                        pend_val = 2'b10;
                     end else begin
                        state_n  = S_WAIT;
                        poll_inc = 1'b1;
                     end
                  end else begin
                     state_n  = S_IDLE;
                     done_inc = 1'b1;
                  end
               end
            end
         S_WAIT:
            if (32'(wait_cnt) == 32'(WAIT_CYCLES - 1)) state_n = S_POLL;
         S_ERR:   state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_n;
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= wr_entry;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         act_op     <= 1'b0;
         act_ch     <= '0;
         act_size   <= '0;
         act_ptr    <= '0;
         hdr_o      <= '0;
         wait_cnt   <= '0;
         poll_cnt   <= '0;
         rty_gap    <= 1'b0;
         done_cnt_o <= '0;
         err_o      <= 1'b0;
         err_code_o <= '0;
         err_pend   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (!push && pop) count <= count - 1'b1;
         if (pop) begin
            act_op   <= head.op;
            act_ch   <= head.ch;
            act_size <= head.size;
            act_ptr  <= head.ptr;
            hdr_o    <= Dw'(hdr_full);
            poll_cnt <= '0;
         end else if (poll_inc) begin
            poll_cnt <= poll_cnt + 1'b1;
         end
         wait_cnt <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;
         rty_gap  <= bus_act && !m_err_i && !m_ack_i && m_rty_i;
         if (done_inc) done_cnt_o <= done_cnt_o + 16'd1;
         if (pend_set) err_pend <= pend_val;
         // A fresh error takes precedence over a simultaneous clear.
         if (state == S_ERR) begin
            err_o      <= 1'b1;
            err_code_o <= err_pend;
         end else if (err_clr_i) begin
            err_o      <= 1'b0;
            err_code_o <= 2'b00;
         end
      end
   end
endmodule

// File: tb/tb_jtag_ni_cmd_engine.sv
// Directed bench for jtag_ni_cmd_engine; acts as the NI Wishbone slave and
// checks every access, error path and counter against hand-computed values.
module tb_jtag_ni_cmd_engine;
   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid_i, cmd_op_i, err_clr_i;
   logic [1:0]  cmd_ch_i;
   logic [8:0]  cmd_size_i;
   logic [29:0] cmd_ptr_i;
   logic [3:0]  cmd_x_i, cmd_y_i;
   logic        cmd_ready_o, m_stb_o, m_cyc_o, m_we_o, busy_o, err_o;
   logic [31:0] hdr_o, m_dat_o, m_addr_o, m_dat_i;
   logic [3:0]  m_sel_o;
   logic [2:0]  m_tag_o;
   logic        m_ack_i, m_err_i, m_rty_i;
   logic [15:0] done_cnt_o;
   logic [1:0]  err_code_o;

   int passed = 0;
   int total  = 0;
   int exp_done = 0;

   jtag_ni_cmd_engine #(
      .NUM_CH(3), .NI_BASE_ADDR(32'h40), .NI_STRIDE(32'h8), .CMD_DEPTH(4),
      .WAIT_CYCLES(2), .POLL_LIMIT(3)
   ) dut (
      .clk(clk), .reset(reset),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
      .cmd_ch_i(cmd_ch_i), .cmd_size_i(cmd_size_i), .cmd_ptr_i(cmd_ptr_i),
      .cmd_x_i(cmd_x_i), .cmd_y_i(cmd_y_i), .hdr_o(hdr_o),
      .m_sel_o(m_sel_o), .m_dat_o(m_dat_o), .m_addr_o(m_addr_o), .m_tag_o(m_tag_o),
      .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o), .m_we_o(m_we_o),
      .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_rty_i(m_rty_i),
      .busy_o(busy_o), .done_cnt_o(done_cnt_o), .err_o(err_o),
      .err_code_o(err_code_o), .err_clr_i(err_clr_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic wait_stb(output int gap, output bit ok);
      gap = 0;
      ok  = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (m_stb_o === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
         gap++;
      end
   endtask

   // resp: 0 = ack, 1 = err, 2 = rty. exp_gap < 0 skips the idle-gap check.
   task automatic bus_step(input string tag, input logic [31:0] a, input logic we,
                           input logic [31:0] d, input int resp, input logic [31:0] rd,
                           input int exp_gap);
      int gap;
      bit ok;
      wait_stb(gap, ok);
      chk({tag, "_seen"}, 32'(ok), 32'd1);
      if (ok) begin
         chk({tag, "_addr"}, m_addr_o, a);
         chk({tag, "_we"}, 32'(m_we_o), 32'(we));
         if (we) chk({tag, "_dat"}, m_dat_o, d);
         chk({tag, "_cyc"}, 32'(m_cyc_o), 32'd1);
         if (exp_gap >= 0) chk({tag, "_gap"}, gap, exp_gap);
         case (resp)
            0: begin m_ack_i = 1'b1; m_dat_i = rd; end
            1: m_err_i = 1'b1;
            default: m_rty_i = 1'b1;
         endcase
         @(negedge clk);
         m_ack_i = 1'b0; m_err_i = 1'b0; m_rty_i = 1'b0; m_dat_i = '0;
      end
   endtask

   task automatic push(input logic op, input logic [1:0] ch, input logic [8:0] size,
                       input logic [29:0] ptr, input logic [3:0] x, input logic [3:0] y);
      cmd_valid_i = 1'b1; cmd_op_i = op; cmd_ch_i = ch; cmd_size_i = size;
      cmd_ptr_i = ptr; cmd_x_i = x; cmd_y_i = y;
      @(negedge clk);
      cmd_valid_i = 1'b0;
   endtask

   task automatic no_bus(input string tag, input int n);
      int seen = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (m_stb_o !== 1'b0 || m_cyc_o !== 1'b0) seen++;
      end
      chk(tag, seen, 0);
   endtask

   initial begin
      int ch_t [4] = '{0, 1, 2, 0};
      logic op_t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [31:0] b;
      reset = 1'b1; cmd_valid_i = 1'b0; cmd_op_i = 1'b0; cmd_ch_i = '0; cmd_size_i = '0;
      cmd_ptr_i = '0; cmd_x_i = '0; cmd_y_i = '0; err_clr_i = 1'b0;
      m_dat_i = '0; m_ack_i = 1'b0; m_err_i = 1'b0; m_rty_i = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      chk("rst_sel", 32'(m_sel_o), 32'hF);
      chk("rst_cyc", 32'(m_cyc_o), 0);
      chk("rst_stb", 32'(m_stb_o), 0);
      chk("rst_we", 32'(m_we_o), 0);
      chk("rst_addr", m_addr_o, 0);
      chk("rst_dat", m_dat_o, 0);
      chk("rst_tag", 32'(m_tag_o), 0);
      chk("rst_hdr", hdr_o, 0);
      chk("rst_done", 32'(done_cnt_o), 0);
      chk("rst_err", 32'(err_o), 0);
      chk("rst_code", 32'(err_code_o), 0);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_ready", 32'(cmd_ready_o), 1);

      // Send on channel 1: busy twice, then idle.
      push(1'b0, 2'd1, 9'd5, 30'h100, 4'd2, 4'd3);
      bus_step("s_size", 32'h4B, 1'b1, 32'd6, 0, 0, -1);
      bus_step("s_ptr", 32'h4D, 1'b1, 32'h400, 0, 0, 0);
      bus_step("s_poll1", 32'h48, 1'b0, 0, 0, 1, 2);
      bus_step("s_poll2", 32'h48, 1'b0, 0, 0, 1, 2);
      bus_step("s_poll3", 32'h48, 1'b0, 0, 0, 0, 2);
      exp_done = 1;
      chk("s_done", 32'(done_cnt_o), exp_done);
      chk("s_hdr", hdr_o, 32'hFF002300);
      chk("s_busy", 32'(busy_o), 0);

      // Receive on channel 0.
      push(1'b1, 2'd0, 9'd0, 30'h3, 4'd1, 4'd0);
      bus_step("r_size", 32'h43, 1'b1, 32'd1, 0, 0, -1);
      bus_step("r_ptr", 32'h44, 1'b1, 32'hC, 0, 0, 0);
      bus_step("r_poll", 32'h48 - 32'h8, 1'b0, 0, 0, 0, 2);
      exp_done = 2;
      chk("r_busy", 32'(busy_o), 0);
      chk("r_done", 32'(done_cnt_o), exp_done);
      chk("r_hdr", hdr_o, 32'hFF001000);

      // Stall on P's first write while filling the FIFO; fifth push is dropped.
      push(1'b0, 2'd2, 9'd0, 30'h0, 4'd0, 4'd0);
      for (int i = 0; i < 4; i++) begin
         chk("f_ready", 32'(cmd_ready_o), 1);
         push(op_t[i], 2'(ch_t[i]), 9'(i + 1), 30'(i + 1), 4'd0, 4'd0);
      end
      chk("f_full", 32'(cmd_ready_o), 0);
      push(1'b1, 2'd1, 9'd9, 30'h9, 4'd0, 4'd0);
      bus_step("p_size", 32'h53, 1'b1, 32'd1, 0, 0, 0);
      bus_step("p_ptr", 32'h55, 1'b1, 32'd0, 0, 0, 0);
      bus_step("p_poll", 32'h50, 1'b0, 0, 0, 0, 2);
      for (int i = 0; i < 4; i++) begin
         b = 32'h40 + 32'(ch_t[i]) * 8;
         bus_step("q_size", b + 3, 1'b1, 32'(i + 2), 0, 0, (i == 0) ? 1 : -1);
         bus_step("q_ptr", b + (op_t[i] ? 32'd4 : 32'd5), 1'b1, 32'((i + 1) * 4), 0, 0, 0);
         bus_step("q_poll", b, 1'b0, 0, 0, 0, 2);
      end
      no_bus("f_no_fifth", 10);
      exp_done = 7;
      chk("f_done", 32'(done_cnt_o), exp_done);
      chk("f_busy", 32'(busy_o), 0);

      // Poll timeout, then the queued command still runs.
      push(1'b0, 2'd1, 9'd2, 30'h10, 4'd0, 4'd0);
      push(1'b1, 2'd0, 9'd0, 30'h1, 4'd0, 4'd0);
      bus_step("t_size", 32'h4B, 1'b1, 32'd3, 0, 0, -1);
      bus_step("t_ptr", 32'h4D, 1'b1, 32'h40, 0, 0, 0);
      bus_step("t_poll1", 32'h48, 1'b0, 0, 0, 1, 2);
      bus_step("t_poll2", 32'h48, 1'b0, 0, 0, 1, 2);
      bus_step("t_poll3", 32'h48, 1'b0, 0, 0, 1, 2);
      bus_step("n_size", 32'h43, 1'b1, 32'd1, 0, 0, 2);
      chk("t_err", 32'(err_o), 1);
      chk("t_code", 32'(err_code_o), 2);
      bus_step("n_ptr", 32'h44, 1'b1, 32'd4, 0, 0, 0);
      bus_step("n_poll", 32'h40, 1'b0, 0, 0, 0, 2);
      exp_done = 8;
      chk("t_done", 32'(done_cnt_o), exp_done);
      err_clr_i = 1'b1;
      @(negedge clk);
      err_clr_i = 1'b0;
      chk("t_clr_err", 32'(err_o), 0);
      chk("t_clr_code", 32'(err_code_o), 0);

      // Retry on the size write: one idle cycle, then an identical reissue.
      push(1'b1, 2'd0, 9'd7, 30'h5, 4'd0, 4'd0);
      bus_step("y_size1", 32'h43, 1'b1, 32'd8, 2, 0, -1);
      chk("y_gap_stb", 32'(m_stb_o), 0);
      chk("y_gap_cyc", 32'(m_cyc_o), 0);
      bus_step("y_size2", 32'h43, 1'b1, 32'd8, 0, 0, 1);
      bus_step("y_ptr", 32'h44, 1'b1, 32'h14, 0, 0, 0);
      bus_step("y_poll", 32'h40, 1'b0, 0, 0, 0, 2);
      exp_done = 9;
      chk("y_done", 32'(done_cnt_o), exp_done);

      // Bus error on the pointer write: no poll follows.
      push(1'b0, 2'd2, 9'd3, 30'h2, 4'd0, 4'd0);
      bus_step("e_size", 32'h53, 1'b1, 32'd4, 0, 0, -1);
      bus_step("e_ptr", 32'h55, 1'b1, 32'd8, 1, 0, 0);
      no_bus("e_no_poll", 8);
      chk("e_err", 32'(err_o), 1);
      chk("e_code", 32'(err_code_o), 1);
      chk("e_done", 32'(done_cnt_o), exp_done);
      err_clr_i = 1'b1;
      @(negedge clk);
      err_clr_i = 1'b0;
      chk("e_clr", 32'(err_o), 0);

      // Channel 3 does not exist with three channels.
      push(1'b0, 2'd3, 9'd1, 30'h1, 4'd0, 4'd0);
      no_bus("i_no_bus", 8);
      chk("i_err", 32'(err_o), 1);
      chk("i_code", 32'(err_code_o), 3);
      chk("i_done", 32'(done_cnt_o), exp_done);

      // Reset asserted while a poll is on the bus with a command queued.
      push(1'b0, 2'd1, 9'd0, 30'h0, 4'd0, 4'd0);
      push(1'b0, 2'd0, 9'd0, 30'h0, 4'd0, 4'd0);
      bus_step("z_size", 32'h4B, 1'b1, 32'd1, 0, 0, -1);
      bus_step("z_ptr", 32'h4D, 1'b1, 32'd0, 0, 0, 0);
      begin
         int gap;
         bit ok;
         wait_stb(gap, ok);
         chk("z_poll_seen", 32'(ok), 1);
         chk("z_poll_addr", m_addr_o, 32'h48);
      end
      #1 reset = 1'b1;
      #1;
      chk("z_cyc", 32'(m_cyc_o), 0);
      chk("z_stb", 32'(m_stb_o), 0);
      chk("z_busy", 32'(busy_o), 0);
      chk("z_ready", 32'(cmd_ready_o), 1);
      chk("z_done", 32'(done_cnt_o), 0);
      chk("z_err", 32'(err_o), 0);
      chk("z_code", 32'(err_code_o), 0);
      chk("z_hdr", hdr_o, 0);
      @(negedge clk);
      reset = 1'b0;
      no_bus("z_queue_dropped", 8);
      chk("z_busy_after", 32'(busy_o), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
